// File: rtl/shiftreg_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// shiftreg_arbiter_pkg
// Shared definitions for the 74hc595 driver arbiter:
//   - N_REQ_DEF : default number of requesters
//   - id_w_of() : requester index width derived from the requester count
//   - state_t   : arbiter FSM state encoding
// ---------------------------------------------------------------------------
package shiftreg_arbiter_pkg;

  localparam int N_REQ_DEF = 4;

  // Index width for a given requester count (clog2 of the count).
  function automatic int id_w_of(input int n);
    return $clog2(n);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/shiftreg_arb_pick.sv
// ---------------------------------------------------------------------------
// shiftreg_arb_pick
// Combinational winner selection. Searches the request vector starting at
// index ptr and wrapping at N_REQ-1 -> 0; the first set bit wins. With ptr
// tied to zero this degenerates to fixed lowest-index priority.
// Ports:
//   req    in  [N_REQ-1:0] eligible requests
//   ptr    in  [ID_W-1:0]  search start index
//   onehot out [N_REQ-1:0] one-hot winner (zero when no request)
//   idx    out [ID_W-1:0]  winner index (zero when no request)
//   any    out             at least one request present
// ---------------------------------------------------------------------------
module shiftreg_arb_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  always_comb begin
    int cand;
    cand   = 0;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(ptr) + k) % N_REQ;
      if (!any && req[cand]) begin
        any          = 1'b1;
        onehot[cand] = 1'b1;
        idx          = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/shiftreg_arbiter.sv
// ---------------------------------------------------------------------------
// shiftreg_arbiter
// Shares one 74hc595 shift-register driver between N_REQ requesters. One
// byte is outstanding at a time: IDLE picks a winner and latches its byte,
// ISSUE strobes the driver and grants, WAIT_BUSY waits for the driver to
// drop ready, WAIT_DONE waits for it to come back and reports completion.
//
// Build option: define SHIFTREG_ARB_RR_EN for round-robin arbitration
// (search starts after the last winner). Undefined: fixed priority, lowest
// index wins, and no pointer register exists.
//
// Ports:
//   i_clk      in   clock, rising edge
//   i_Reset    in   synchronous active-high reset
//   i_Req      in   [N_REQ-1:0]   request levels, held until granted
//   i_ReqData  in   [8*N_REQ-1:0] byte k at [8k+7:8k]
//   o_Grant    out  [N_REQ-1:0]   one-cycle one-hot grant (ISSUE)
//   o_Done     out  one-cycle completion pulse
//   o_DoneId   out  [ID_W-1:0]    requester index of the completed byte
//   o_Data     out  [7:0]         byte to the driver
//   o_Enable   out  one-cycle driver start strobe (ISSUE)
//   i_Ready    in   driver idle
//   o_Busy     out  high outside IDLE
// ---------------------------------------------------------------------------
module shiftreg_arbiter
  import shiftreg_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int ID_W  = id_w_of(N_REQ)
) (
  input  logic               i_clk,
  input  logic               i_Reset,
  input  logic [N_REQ-1:0]   i_Req,
  input  logic [8*N_REQ-1:0] i_ReqData,
  output logic [N_REQ-1:0]   o_Grant,
  output logic               o_Done,
  output logic [ID_W-1:0]    o_DoneId,
  output logic [7:0]         o_Data,
  output logic               o_Enable,
  input  logic               i_Ready,
  output logic               o_Busy
);

  state_t            state_reg, state_next;
  logic [N_REQ-1:0]  req_reg;
  logic [N_REQ-1:0]  eligible;
  logic [7:0]        data_reg;
  logic [N_REQ-1:0]  win_onehot_reg;
  logic [ID_W-1:0]   win_idx_reg;
  logic              done_reg;
  logic [ID_W-1:0]   done_id_reg;

  logic              start;
  logic              done_next;
  logic [N_REQ-1:0]  grant;
  logic              enable;
  logic              busy;

  logic [N_REQ-1:0]  pick_onehot;
  logic [ID_W-1:0]   pick_idx;
  logic              pick_any;
  logic [ID_W-1:0]   pick_ptr;

  logic [7:0]        req_byte [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bytes
    assign req_byte[gi] = i_ReqData[8*gi +: 8];
  end

  // A request must be seen on two consecutive edges before it can win.
  // This gives the fixed two-cycle request-to-strobe latency and means a
  // single-cycle request blip never produces a grant.
  assign eligible = i_Req & req_reg;

  shiftreg_arb_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req    (eligible),
    .ptr    (pick_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

`ifdef SHIFTREG_ARB_RR_EN
  // Pointer holds the index where the next search begins (one past the
  // last winner), so after reset index 0 is searched first.
  logic [ID_W-1:0] ptr_reg;

  always_ff @(posedge i_clk) begin
    if (i_Reset) begin
      ptr_reg <= '0;
    end else if (start) begin
      if (pick_idx == ID_W'(N_REQ - 1)) begin
        ptr_reg <= '0;
      end else begin
        ptr_reg <= pick_idx + ID_W'(1);
      end
    end
  end

  assign pick_ptr = ptr_reg;
`else
  assign pick_ptr = '0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_Reset) begin
      state_reg      <= ST_IDLE;
      req_reg        <= '0;
      data_reg       <= '0;
      win_onehot_reg <= '0;
      win_idx_reg    <= '0;
      done_reg       <= 1'b0;
      done_id_reg    <= '0;
    end else begin
      state_reg <= state_next;
      req_reg   <= i_Req;
      done_reg  <= done_next;
      if (start) begin
        data_reg       <= req_byte[pick_idx];
        win_onehot_reg <= pick_onehot;
        win_idx_reg    <= pick_idx;
      end
      if (done_next) begin
        done_id_reg <= win_idx_reg;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    done_next  = 1'b0;
    grant      = '0;
    enable     = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      ST_IDLE: begin
        busy = 1'b0;
        // A driver that is still busy (i_Ready low) blocks arbitration.
        if (pick_any && i_Ready) begin
          start      = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        enable     = 1'b1;
        grant      = win_onehot_reg;
        state_next = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!i_Ready) begin
          state_next = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (i_Ready) begin
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign o_Grant  = grant;
  assign o_Enable = enable;
  assign o_Busy   = busy;
  assign o_Data   = data_reg;
  assign o_Done   = done_reg;
  assign o_DoneId = done_id_reg;

endmodule

// File: doc/shiftreg_arbiter.md
SHIFTREG_ARBITER -- requirements
Module: shiftreg_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one 74hc595 shift register driver (range 2..8).
REQ-002 Parameter ID_W, default 2, width of requester index; SHALL equal clog2(N_REQ).
REQ-003 i_clk  input  1  system clock; all logic on rising edge.
REQ-004 i_Reset  input  1  synchronous, active-high reset.
REQ-005 i_Req  input  N_REQ  per-requester request level; held high until granted.
REQ-006 i_ReqData  input  8*N_REQ  requester k byte at bits [8k+7:8k]; stable while i_Req[k] high.
REQ-007 o_Grant  output  N_REQ  one-hot, one-cycle pulse; byte of requester k accepted.
REQ-008 o_Done  output  1  one-cycle pulse when the driver completes the granted byte.
REQ-009 o_DoneId  output  ID_W  index of the requester whose byte completed; valid with o_Done.
REQ-010 o_Data  output  8  byte to the driver data input.
REQ-011 o_Enable  output  1  start strobe to the driver, one cycle wide.
REQ-012 i_Ready  input  1  driver ready; high when idle, low while shifting/latching.
REQ-013 o_Busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-015 IDLE: if any i_Req bit high and i_Ready=1, select winner, register its byte into o_Data and its index, go to ISSUE; otherwise stay.
REQ-016 ISSUE (exactly one cycle): o_Enable=1, o_Grant[winner]=1, go to WAIT_BUSY.
REQ-017 WAIT_BUSY: stay until i_Ready=0, then go to WAIT_DONE; o_Enable=0.
REQ-018 WAIT_DONE: on i_Ready=1, pulse o_Done with o_DoneId=winner for one cycle, go to IDLE.
REQ-019 Request-to-o_Enable latency SHALL be 2 cycles when the block is IDLE and i_Ready=1.
REQ-020 o_Data SHALL hold the granted byte from ISSUE until the next IDLE->ISSUE transition.
REQ-021 At most one byte outstanding; no new grant while o_Busy=1.
REQ-022 i_Req deasserted before grant SHALL withdraw the request with no grant and no side effect.
REQ-023 A requester may reassert i_Req in the cycle after its o_Grant; it then competes normally.
REQ-024 i_Ready=0 while IDLE (driver still busy) SHALL block arbitration; no o_Enable issued.
REQ-025 o_Grant, o_Enable, o_Done SHALL never be high outside their single defined cycle.

Reset
REQ-026 On i_Reset: state=IDLE, o_Grant=0, o_Enable=0, o_Done=0, o_DoneId=0, o_Data=0, o_Busy=0, round-robin pointer=0.
REQ-027 Reset mid-transfer SHALL abort tracking with no o_Done; the next grant waits for i_Ready=1 per REQ-024.
REQ-028 Reset has priority over all requests in the same cycle.

Configuration
REQ-029 Macro SHIFTREG_ARB_RR_EN defined: round-robin; search starts at index after the last winner, wrapping N_REQ-1 -> 0; pointer updates only on grant.
REQ-030 SHIFTREG_ARB_RR_EN undefined: fixed priority, lowest index wins; pointer logic absent.

Structure
REQ-031 Shared package SHALL hold the FSM state encoding, N_REQ default and ID_W derivation.
REQ-032 Winner selection SHALL be a sub-module shiftreg_arb_pick (request vector + pointer in, one-hot and index out, combinational).

Verification
REQ-033 Single request: i_Req=0001, data 0xA5, i_Ready=1 -> o_Enable and o_Grant=0001 2 cycles later, o_Data=0xA5; o_Done, o_DoneId=0 after i_Ready returns high.
REQ-034 Contention, RR on: i_Req=1111 held -> grants in order 0,1,2,3,0; RR off -> grant 0 every time.
REQ-035 Driver busy at start: i_Ready=0, i_Req=0100 -> no o_Enable until i_Ready=1, then grant 0100.
REQ-036 Reset during WAIT_DONE -> all outputs 0 next cycle, no o_Done; grant resumes only after i_Ready=1.
REQ-037 Withdrawal: i_Req[2] high 1 cycle while busy, then low -> no grant to 2.
REQ-038 With the real shift register driver model: bytes 0x81 (req 1) and 0x3C (req 3) -> serial output MSB first, exactly one RCLK pulse per byte, in grant order.
